// File: rtl/decode_instruction_queue.sv
// decode_instruction_queue
// Decoupling FIFO between the 4-wide decode stages and instruction interchange.
// Up to four enabled input slots are compacted in program order into a
// circular buffer. The two oldest entries are presented to the consumer,
// which retires 0, 1 or 2 per cycle. Flush discards everything.
//
// Ports:
//   clock_i, reset_i (async, active-low), flush_i
//   enable1_i..enable4_i, payload1_i..payload4_i : input slots, slot 1 oldest
//   ready_o   : at least four free entries (from count register only)
//   dropped_o : registered pulse, an input set arrived while not ready
//   valid1_o/valid2_o, payload1_o/payload2_o      : head and head+1
//   take1_i, take2_i : retire head / head+1
//   count_o   : occupancy 0..depth
module decode_instruction_queue #(
  parameter int unsigned payloadWidth = 256,
  parameter int unsigned depth        = 16,
  parameter int unsigned ptrWidth     = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic                    enable1_i,
  input  logic                    enable2_i,
  input  logic                    enable3_i,
  input  logic                    enable4_i,
  input  logic [payloadWidth-1:0] payload1_i,
  input  logic [payloadWidth-1:0] payload2_i,
  input  logic [payloadWidth-1:0] payload3_i,
  input  logic [payloadWidth-1:0] payload4_i,
  output logic                    ready_o,
  output logic                    dropped_o,
  output logic                    valid1_o,
  output logic                    valid2_o,
  output logic [payloadWidth-1:0] payload1_o,
  output logic [payloadWidth-1:0] payload2_o,
  input  logic                    take1_i,
  input  logic                    take2_i,
  output logic [ptrWidth:0]       count_o
);

  localparam int unsigned CntW  = ptrWidth + 1;
  localparam int unsigned Slots = 4;

  logic [payloadWidth-1:0] r_storage [depth];
  logic [ptrWidth-1:0]     r_head;
  logic [ptrWidth-1:0]     r_tail;
  logic [CntW-1:0]         r_count;
  logic                    r_dropped;

  logic [Slots-1:0]        w_en;
  logic [payloadWidth-1:0] w_pl [Slots];
  logic [2:0]              w_off [Slots];
  logic [2:0]              w_nwrite;
  logic [2:0]              w_nwrite_eff;
  logic [1:0]              w_nread;
  logic                    w_ready;
  logic                    w_valid1;
  logic                    w_valid2;
  logic                    w_take1;
  logic                    w_take2;
  logic                    w_write_ok;
  logic                    w_any_en;
  logic [ptrWidth-1:0]     w_head1;

  assign w_en    = {enable4_i, enable3_i, enable2_i, enable1_i};
  assign w_pl[0] = payload1_i;
  assign w_pl[1] = payload2_i;
  assign w_pl[2] = payload3_i;
  assign w_pl[3] = payload4_i;

  // Compaction: each enabled slot lands at tail + (number of enabled older slots)
  always_comb begin
    w_off[0] = 3'd0;
    w_off[1] = 3'(w_en[0]);
    w_off[2] = 3'(w_en[0]) + 3'(w_en[1]);
    w_off[3] = 3'(w_en[0]) + 3'(w_en[1]) + 3'(w_en[2]);
    w_nwrite = w_off[3] + 3'(w_en[3]);
  end

  assign w_any_en     = |w_en;
  assign w_ready      = (r_count <= CntW'(depth - 4));
  assign w_valid1     = (r_count >= CntW'(1));
  assign w_valid2     = (r_count >= CntW'(2));
  assign w_write_ok   = w_ready & ~flush_i;
  assign w_nwrite_eff = w_ready ? w_nwrite : 3'd0;

  // take2 only counts together with a valid take1
  assign w_take1 = take1_i & w_valid1;
  assign w_take2 = w_take1 & take2_i & w_valid2;
  assign w_nread = w_take2 ? 2'd2 : (w_take1 ? 2'd1 : 2'd0);

  assign w_head1 = r_head + ptrWidth'(1);

  // Storage writes
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < int'(depth); i++) begin
        r_storage[i] <= '0;
      end
    end else if (w_write_ok) begin
      for (int s = 0; s < int'(Slots); s++) begin
        if (w_en[s]) begin
          r_storage[r_tail + ptrWidth'(w_off[s])] <= w_pl[s];
        end
      end
    end
  end

  // Pointers, occupancy and drop pulse; flush wins over read and write
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_dropped <= 1'b0;
    end else if (flush_i) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_head    <= r_head + ptrWidth'(w_nread);
      r_tail    <= r_tail + ptrWidth'(w_nwrite_eff);
      r_count   <= r_count + CntW'(w_nwrite_eff) - CntW'(w_nread);
      r_dropped <= ~w_ready & w_any_en;
    end
  end

  assign ready_o    = w_ready;
  assign valid1_o   = w_valid1;
  assign valid2_o   = w_valid2;
  assign payload1_o = r_storage[r_head];
  assign payload2_o = r_storage[w_head1];
  assign count_o    = r_count;
  assign dropped_o  = r_dropped;

endmodule

// File: tb/tb_decode_instruction_queue.sv
// Self-checking bench for decode_instruction_queue: a queue-based reference
// model plus directed literal checks and a randomized streaming phase.
module tb_decode_instruction_queue;

  localparam int unsigned PW    = 256;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [3:0]    en;
  logic [PW-1:0] pl [4];
  logic          take1;
  logic          take2;

  logic          ready_o;
  logic          dropped_o;
  logic          valid1_o;
  logic          valid2_o;
  logic [PW-1:0] payload1_o;
  logic [PW-1:0] payload2_o;
  logic [4:0]    count_o;

  int total = 0;
  int bad   = 0;

  decode_instruction_queue #(
    .payloadWidth(PW),
    .depth(DEPTH),
    .ptrWidth(4)
  ) dut (
    .clock_i   (clk),
    .reset_i   (rst_n),
    .flush_i   (flush),
    .enable1_i (en[0]),
    .enable2_i (en[1]),
    .enable3_i (en[2]),
    .enable4_i (en[3]),
    .payload1_i(pl[0]),
    .payload2_i(pl[1]),
    .payload3_i(pl[2]),
    .payload4_i(pl[3]),
    .ready_o   (ready_o),
    .dropped_o (dropped_o),
    .valid1_o  (valid1_o),
    .valid2_o  (valid2_o),
    .payload1_o(payload1_o),
    .payload2_o(payload2_o),
    .take1_i   (take1),
    .take2_i   (take2),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: queue of live entries in program order
  logic [PW-1:0] mq [$];
  bit            exp_drop;
  int            n_written;
  int            n_read;
  int            m_sz;
  bit            m_rdy;
  int            m_n;

  always @(negedge rst_n) begin
    mq.delete();
    exp_drop = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_sz  = mq.size();
      m_rdy = (m_sz <= int'(DEPTH) - 4);
      if (flush) begin
        mq.delete();
        exp_drop = 1'b0;
      end else begin
        m_n = 0;
        if (take1 && m_sz >= 1) m_n = 1;
        if (m_n == 1 && take2 && m_sz >= 2) m_n = 2;
        for (int k = 0; k < m_n; k++) void'(mq.pop_front());
        n_read += m_n;
        if (m_rdy) begin
          for (int s = 0; s < 4; s++) begin
            if (en[s]) begin
              mq.push_back(pl[s]);
              n_written++;
            end
          end
        end
        exp_drop = !m_rdy && (en != 4'd0);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("count", PW'(count_o), PW'(mq.size()));
    chk("ready", PW'(ready_o), PW'(mq.size() <= int'(DEPTH) - 4));
    chk("valid1", PW'(valid1_o), PW'(mq.size() >= 1));
    chk("valid2", PW'(valid2_o), PW'(mq.size() >= 2));
    chk("dropped", PW'(dropped_o), PW'(exp_drop));
    if (mq.size() >= 1) chk("payload1", payload1_o, mq[0]);
    if (mq.size() >= 2) chk("payload2", payload2_o, mq[1]);
  end

  function automatic logic [PW-1:0] rnd_pl();
    logic [PW-1:0] v;
    for (int w = 0; w < int'(PW / 32); w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    en    = 4'd0;
    take1 = 1'b0;
    take2 = 1'b0;
    flush = 1'b0;
  endtask

  // Apply one input set for one edge, then return to idle at edge + 1
  task automatic put(input logic [3:0] e, input logic t1, input logic t2, input logic f);
    en    = e;
    take1 = t1;
    take2 = t2;
    flush = f;
    for (int s = 0; s < 4; s++) pl[s] = rnd_pl();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  logic [PW-1:0] pa, pb, pc, pd, pe;
  int            w0;
  int            r0;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_written = 0;
    n_read    = 0;
    exp_drop  = 1'b0;
    rst_n     = 1'b0;
    idle_inputs();
    for (int s = 0; s < 4; s++) pl[s] = '0;
    #2;
    chk("rst_ready", PW'(ready_o), PW'(1));
    chk("rst_count", PW'(count_o), PW'(0));
    chk("rst_valid1", PW'(valid1_o), PW'(0));
    chk("rst_payload1", payload1_o, '0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Compaction: enables 1,0,1,1 with A,B,C,D
    pa = PW'(256'hA); pb = PW'(256'hB); pc = PW'(256'hC); pd = PW'(256'hD);
    en = 4'b1101; pl[0] = pa; pl[1] = pb; pl[2] = pc; pl[3] = pd;
    @(posedge clk); #1; idle_inputs();
    chk("cmp_count", PW'(count_o), PW'(3));
    chk("cmp_p1", payload1_o, pa);
    chk("cmp_p2", payload2_o, pc);
    put(4'b0000, 1'b1, 1'b1, 1'b0);
    chk("cmp_take_p1", payload1_o, pd);
    chk("cmp_take_count", PW'(count_o), PW'(1));
    put(4'b0000, 1'b1, 1'b0, 1'b0);

    // Fill and backpressure
    for (int i = 0; i < 3; i++) put(4'b1111, 1'b0, 1'b0, 1'b0);
    chk("fill12_count", PW'(count_o), PW'(12));
    chk("fill12_ready", PW'(ready_o), PW'(1));
    put(4'b0001, 1'b0, 1'b0, 1'b0);
    chk("fill13_count", PW'(count_o), PW'(13));
    chk("fill13_ready", PW'(ready_o), PW'(0));
    put(4'b1111, 1'b0, 1'b0, 1'b0);
    chk("drop_count", PW'(count_o), PW'(13));
    chk("drop_pulse", PW'(dropped_o), PW'(1));
    put(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("drop_end", PW'(dropped_o), PW'(0));
    for (int i = 0; i < 7; i++) put(4'b0000, 1'b1, 1'b1, 1'b0);
    chk("drain_count", PW'(count_o), PW'(0));

    // Concurrent read and write
    put(4'b1111, 1'b0, 1'b0, 1'b0);
    put(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("conc5_count", PW'(count_o), PW'(5));
    put(4'b1011, 1'b1, 1'b1, 1'b0);
    chk("conc6_count", PW'(count_o), PW'(6));
    for (int i = 0; i < 3; i++) put(4'b0000, 1'b1, 1'b1, 1'b0);

    // Flush priority
    put(4'b1111, 1'b0, 1'b0, 1'b0);
    put(4'b0111, 1'b0, 1'b0, 1'b0);
    chk("fl7_count", PW'(count_o), PW'(7));
    put(4'b1111, 1'b1, 1'b0, 1'b1);
    chk("fl_count", PW'(count_o), PW'(0));
    chk("fl_valid1", PW'(valid1_o), PW'(0));
    chk("fl_dropped", PW'(dropped_o), PW'(0));
    chk("fl_ready", PW'(ready_o), PW'(1));

    // Random streaming with wrap-around
    w0 = n_written;
    r0 = n_read;
    for (int i = 0; i < 300; i++) begin
      put(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 10; i++) put(4'b0000, 1'b1, 1'b1, 1'b0);
    chk("stream_written", PW'(n_written - w0 >= 2 * int'(DEPTH) + 8), PW'(1));
    chk("stream_read", PW'(n_read - r0 >= 2 * int'(DEPTH)), PW'(1));
    chk("stream_empty", PW'(count_o), PW'(0));

    // Asynchronous reset mid-operation
    put(4'b1111, 1'b0, 1'b0, 1'b0);
    put(4'b1111, 1'b0, 1'b0, 1'b0);
    put(4'b0010, 1'b0, 1'b0, 1'b0);
    chk("ar9_count", PW'(count_o), PW'(9));
    en = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid1", PW'(valid1_o), PW'(0));
    chk("ar_count", PW'(count_o), PW'(0));
    chk("ar_p1", payload1_o, '0);
    chk("ar_p2", payload2_o, '0);
    chk("ar_ready", PW'(ready_o), PW'(1));
    idle_inputs();
    @(negedge clk);
    #1 rst_n = 1'b1;
    pe = PW'(256'hE0E0_1234);
    en = 4'b0001;
    pl[0] = pe;
    @(posedge clk); #1; idle_inputs();
    chk("ar_e_p1", payload1_o, pe);
    chk("ar_e_count", PW'(count_o), PW'(1));
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
